// File: rtl/mimosa_uart_telemetry.sv
// mimosa_uart_telemetry: snapshots model buses on each model_clk rise and streams a framed 6-byte 8N1 UART packet
module mimosa_uart_telemetry #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       model_clk,
  input  logic [7:0] uo_out,
  input  logic [7:0] uio_out,
  input  logic [7:0] debug,
  output logic       usb_tx,
  output logic       busy,
  output logic [7:0] overrun_cnt
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0] bit_idx, bit_n, byte_idx, byte_n;
  logic [7:0] seq, seq_n, s_seq, s_uo, s_uio, s_dbg, cur;
  logic model_clk_q, rise, tick, tx_n;
  assign rise = model_clk & ~model_clk_q;
  assign tick = baud == LAST;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    baud_n = (state == IDLE || tick) ? '0 : baud + BW'(1);
    bit_n = bit_idx;
    byte_n = byte_idx;
    seq_n = seq;
    case (state)
      IDLE: if (rise) begin
        state_n = START;
        byte_n = 3'd0;
      end
      START: if (tick) begin
        state_n = DATA;
        bit_n = 3'd0;
      end
      DATA: if (tick) begin
        state_n = bit_idx == 3'd7 ? STOP : DATA;
        bit_n = bit_idx + 3'd1;
      end
      STOP: if (tick) begin
        state_n = byte_idx == 3'd5 ? IDLE : START;
        byte_n = byte_idx == 3'd5 ? 3'd0 : byte_idx + 3'd1;
        seq_n = byte_idx == 3'd5 ? seq + 8'd1 : seq;
      end
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    cur = byte_n == 3'd0 ? 8'hA5 :
          byte_n == 3'd1 ? s_seq :
          byte_n == 3'd2 ? s_uo :
          byte_n == 3'd3 ? s_uio :
          byte_n == 3'd4 ? s_dbg :
          s_seq + s_uo + s_uio + s_dbg;
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? cur[bit_n] : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      baud <= '0;
      bit_idx <= 3'd0;
      byte_idx <= 3'd0;
      seq <= 8'd0;
      s_seq <= 8'd0;
      s_uo <= 8'd0;
      s_uio <= 8'd0;
      s_dbg <= 8'd0;
      model_clk_q <= 1'b1;
      usb_tx <= 1'b1;
      overrun_cnt <= 8'd0;
    end else begin
      state <= state_n;
      baud <= baud_n;
      bit_idx <= bit_n;
      byte_idx <= byte_n;
      seq <= seq_n;
      model_clk_q <= model_clk;
      usb_tx <= tx_n;
      if (rise && !busy) begin
        s_seq <= seq;
        s_uo <= uo_out;
        s_uio <= uio_out;
        s_dbg <= debug;
      end
      if (rise && busy && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_mimosa_uart_telemetry.sv
// tb_mimosa_uart_telemetry: scoreboard bench decoding usb_tx against a cycle-count packet model
module tb_mimosa_uart_telemetry;
  localparam int CPB = 4;
  localparam int PKT = 60 * CPB;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic model_clk = 1'b1;
  logic [7:0] uo = 8'h00, uio = 8'h00, dbg = 8'h00;
  logic usb_tx, busy;
  logic [7:0] overrun_cnt;
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  int m_rem = 0;
  logic [7:0] m_seq = 8'd0, m_ov = 8'd0;
  logic mq = 1'b1;
  logic m_active = 1'b0;
  int m_cnt = 0;
  logic [7:0] m_sh = 8'h00, e;
  mimosa_uart_telemetry #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .model_clk(model_clk),
    .uo_out(uo), .uio_out(uio), .debug(dbg),
    .usb_tx(usb_tx), .busy(busy), .overrun_cnt(overrun_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (rst) begin
      m_rem <= 0;
      m_seq <= 8'd0;
      m_ov <= 8'd0;
      mq <= 1'b1;
      exp_q.delete();
    end else begin
      mq <= model_clk;
      if (m_rem != 0) m_rem <= m_rem - 1;
      if (m_rem == 1) m_seq <= m_seq + 8'd1;
      if (model_clk && !mq && m_rem != 0 && m_ov != 8'hFF) m_ov <= m_ov + 8'd1;
      if (model_clk && !mq && m_rem == 0) begin
        m_rem <= PKT;
        exp_q.push_back(8'hA5);
        exp_q.push_back(m_seq);
        exp_q.push_back(uo);
        exp_q.push_back(uio);
        exp_q.push_back(dbg);
        exp_q.push_back(8'(m_seq + uo + uio + dbg));
      end
    end
  end
  always @(negedge clk) begin
    if (rst) m_active = 1'b0;
    else if (!m_active) begin
      if (usb_tx === 1'b0) begin
        m_active = 1'b1;
        m_cnt = 0;
      end
    end else begin
      m_cnt++;
      if (m_cnt >= 5 && m_cnt <= 33 && m_cnt % 4 == 1) m_sh = {usb_tx, m_sh[7:1]};
      if (m_cnt == 37) begin
        m_active = 1'b0;
        checks++;
        if (usb_tx !== 1'b1) begin
          errors++;
          $display("FAIL stop_bit got %b exp 1", usb_tx);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL uart_byte got %h exp none", m_sh);
        end else begin
          e = exp_q.pop_front();
          if (m_sh !== e) begin
            errors++;
            $display("FAIL uart_byte got %h exp %h", m_sh, e);
          end
        end
      end
    end
  end
  task automatic pulse(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    @(posedge clk);
    #1;
    uo = a;
    uio = b;
    dbg = c;
    model_clk = 1'b1;
    @(posedge clk);
    #1;
    model_clk = 1'b0;
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 4 * PKT; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout got busy %b exp 0", busy);
    end
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (usb_tx !== 1'b1 || busy !== 1'b0 || overrun_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_values got tx %b busy %b ov %h exp 1 0 00", usb_tx, busy, overrun_cnt);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (usb_tx !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL held_high_no_trigger got tx %b busy %b exp 1 0", usb_tx, busy);
    end
    model_clk = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  task automatic test_basic();
    int n;
    @(posedge clk);
    #1;
    uo = 8'h12;
    uio = 8'h34;
    dbg = 8'h56;
    model_clk = 1'b1;
    @(negedge clk);
    checks++;
    if (usb_tx !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL pre_edge got tx %b busy %b exp 1 0", usb_tx, busy);
    end
    @(posedge clk);
    #1;
    model_clk = 1'b0;
    @(negedge clk);
    checks++;
    if (usb_tx !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL latency got tx %b busy %b exp 0 1", usb_tx, busy);
    end
    n = 1;
    for (int i = 0; i < 4 * PKT; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    checks++;
    if (n != PKT) begin
      errors++;
      $display("FAIL busy_len got %0d exp %0d", n, PKT);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL basic_bytes_left got %0d exp 0", exp_q.size());
    end
  endtask
  task automatic test_snapshot();
    pulse(8'hDE, 8'hAD, 8'hBE);
    for (int i = 0; i < PKT + 4; i++) begin
      @(posedge clk);
      #1;
      uo = 8'($urandom);
      uio = 8'($urandom);
      dbg = 8'($urandom);
    end
    wait_idle();
  endtask
  task automatic test_back_to_back();
    pulse(8'h01, 8'h02, 8'h03);
    wait_idle();
    uo = 8'hF0;
    uio = 8'h0F;
    dbg = 8'h77;
    model_clk = 1'b1;
    @(posedge clk);
    #1;
    model_clk = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || overrun_cnt !== 8'd0) begin
      errors++;
      $display("FAIL back_to_back got busy %b ov %h exp 1 00", busy, overrun_cnt);
    end
    wait_idle();
  endtask
  task automatic test_seq_wrap();
    for (int k = 0; k < 257; k++) begin
      pulse(8'($urandom), 8'($urandom), 8'($urandom));
      wait_idle();
    end
    checks++;
    if (overrun_cnt !== 8'd0) begin
      errors++;
      $display("FAIL seq_wrap_ov got %h exp 00", overrun_cnt);
    end
  endtask
  task automatic test_overrun();
    pulse(8'hAA, 8'hBB, 8'hCC);
    for (int k = 0; k < 3; k++) begin
      repeat (20) @(posedge clk);
      pulse(8'h11, 8'h22, 8'h33);
    end
    @(negedge clk);
    checks++;
    if (overrun_cnt !== 8'd3 || overrun_cnt !== m_ov) begin
      errors++;
      $display("FAIL overrun_3 got %h exp 03 model %h", overrun_cnt, m_ov);
    end
    wait_idle();
    for (int k = 0; k < 300; k++) pulse(8'(k), 8'(k * 3), 8'(k * 7));
    wait_idle();
    checks++;
    if (overrun_cnt !== 8'hFF || m_ov !== 8'hFF) begin
      errors++;
      $display("FAIL overrun_sat got %h exp ff model %h", overrun_cnt, m_ov);
    end
  endtask
  task automatic test_reset_mid();
    pulse(8'h5A, 8'hC3, 8'h3C);
    repeat (130) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (usb_tx !== 1'b1 || busy !== 1'b0 || overrun_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid got tx %b busy %b ov %h exp 1 0 00", usb_tx, busy, overrun_cnt);
    end
    rst = 1'b0;
    checks++;
    if (m_seq !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid_seq got %h exp 00", m_seq);
    end
    pulse(8'h10, 8'h20, 8'h30);
    wait_idle();
  endtask
  initial begin
    test_reset();
    test_basic();
    test_snapshot();
    test_back_to_back();
    test_seq_wrap();
    test_overrun();
    test_reset_mid();
    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || m_active) begin
      errors++;
      $display("FAIL leftover_bytes got %0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mimosa_uart_telemetry.md
# mimosa_uart_telemetry

Downstream telemetry stage for the FPGA build of the moody mimosa model. On every rising edge of the prescaled model clock it snapshots the model's `uo_out`, `uio_out` and `debug` buses. It then streams them as a fixed 6-byte framed packet over the board's `usb_tx` UART line (8N1, LSB first). The host can log mood/state evolution without a logic analyser.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 868: system clock cycles per UART bit (100 MHz / 115200); legal range ≥ 2.

Ports:
- `clk`  in  1  system clock (100 MHz on board).
- `rst`  in  1  synchronous reset, active-high; sampled on `clk` rising edge.
- `model_clk`  in  1  prescaled model clock level, synchronous to `clk`; its rising edge is the packet trigger.
- `uo_out`  in  8  model output bus to capture.
- `uio_out`  in  8  model bidirectional-output bus to capture.
- `debug`  in  8  model debug bus to capture.
- `usb_tx`  out  1  UART transmit line, idle high, registered.
- `busy`  out  1  high while a packet is in flight.
- `overrun_cnt`  out  8  number of triggers dropped because `busy`; saturates at 255.

## Operation

- Edge detect: register `model_clk_q`. `rise = model_clk & ~model_clk_q`.
- Trigger accept: `rise` is accepted only at an edge where state is IDLE.
  - On accept: capture `uo_out`, `uio_out`, `debug` and the current `seq` into snapshot registers.
  - Enter START for byte 0.
- Packet, in transmit order:
  - byte 0: 0xA5
  - byte 1: `seq`
  - byte 2: `uo_out`
  - byte 3: `uio_out`
  - byte 4: `debug`
  - byte 5: checksum = (byte1 + byte2 + byte3 + byte4) mod 256
- All packet bytes come from the snapshot. Input changes after capture do not affect the packet.
- States:
  - IDLE: `usb_tx`=1.
  - START: `usb_tx`=0 for `CLKS_PER_BIT` cycles, then DATA.
  - DATA: bits 0..7 of the current byte, each held `CLKS_PER_BIT` cycles, then STOP.
  - STOP: `usb_tx`=1 for `CLKS_PER_BIT` cycles.
    - If byte index < 5: increment index and go to START. There is no inter-byte gap.
    - Otherwise: go to IDLE and increment `seq`.
- `seq` is an 8-bit counter, wraps 255→0. The first packet after reset carries `seq`=0.
- `busy` = (state != IDLE).
- Overrun: a `rise` while state != IDLE is dropped and increments `overrun_cnt` (saturating at 255). This includes a rise in the last cycle of the final STOP bit. The packet in flight is unaffected.

## Timing

- Reset values:
  - `usb_tx`=1, `busy`=0, `overrun_cnt`=0
  - `seq`=0, state IDLE, all counters 0
  - `model_clk_q`=1, so a `model_clk` held high through reset does not fire a trigger.
- Latency: if `model_clk` is first seen high at edge N, `usb_tx` goes low and `busy` goes high after edge N.
- Packet duration is exactly 60·`CLKS_PER_BIT` cycles from `usb_tx` falling to `busy` falling.
- `busy` falls at the same edge where the last stop bit completes. A `rise` at the following edge is accepted.
- Counters used:
  - baud counter 0..`CLKS_PER_BIT`-1
  - bit index 0..7
  - byte index 0..5
- Reset mid-packet: at the next edge, `usb_tx` returns to 1 and all state returns to reset values. The partial packet is abandoned.
- Width rules:
  - Checksum is an 8-bit sum with carry discarded.
  - `overrun_cnt` never wraps.

## Test plan

- Basic packet (`CLKS_PER_BIT`=4): `uo_out`=0x12, `uio_out`=0x34, `debug`=0x56, one `model_clk` rise after reset -> `usb_tx` decodes A5 00 12 34 56 9C. `busy` is high for exactly 240 cycles. `usb_tx` falls 1 cycle after `model_clk` rises.
- Snapshot stability: change all buses every cycle after the trigger -> the packet still carries the values present at the accepting edge.
- Sequence and wrap: 257 spaced triggers -> `seq` bytes 0x00..0xFF then 0x00. Checksums match the formula each time.
- Overrun: three rises during one packet -> that packet is intact and `overrun_cnt`=3. Drive 300 overlapping rises -> `overrun_cnt` holds 255.
- Reset cases: `model_clk`=1 while `rst` is released -> no packet sent. `rst` asserted during byte 3 -> `usb_tx`=1 and `busy`=0 after the next edge. The next trigger sends a packet with `seq`=0.
- Back-to-back: a rise in the cycle after `busy` falls -> accepted, and the second packet follows with `overrun_cnt` unchanged.
